// File: rtl/ex_mc_pkg.sv
// Shared definitions for the ex_mc execute stage: opcodes, instruction field positions,
// FSM state encoding and the small decode helpers used by the stage.
package ex_mc_pkg;

  localparam logic [3:0] ADD_op  = 4'h0;
  localparam logic [3:0] ADDI_op = 4'h1;
  localparam logic [3:0] SUB_op  = 4'h2;
  localparam logic [3:0] MUL_op  = 4'h3;
  localparam logic [3:0] DIV_op  = 4'h4;
  localparam logic [3:0] AND_op  = 4'h5;
  localparam logic [3:0] OR_op   = 4'h6;
  localparam logic [3:0] NOT_op  = 4'h7;
  localparam logic [3:0] MOV_op  = 4'h8;
  localparam logic [3:0] BNE_op  = 4'h9;
  localparam logic [3:0] BLT_op  = 4'hA;

  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned OPC_MSB = 3;
  localparam int unsigned OFF_LSB = 10;
  localparam int unsigned OFF_MSB = 15;

  typedef enum logic {
    StIdle = 1'b0,
    StDiv  = 1'b1
  } ex_state_e;

endpackage

// File: rtl/ex_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first, DATA_W cycles.
// done is asserted combinationally during the last iteration with the final quotient.
module ex_div_iter #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              kill,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient
);

  localparam int unsigned CntW = $clog2(DATA_W);

  logic [CntW-1:0]   r_cnt;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_dvs;
  logic              r_busy;
  logic [DATA_W:0]   w_shift;
  logic [DATA_W:0]   w_diff;
  logic              w_qbit;

  // Dividend bits are shifted out of r_quo as quotient bits are shifted in.
  assign w_shift  = {r_rem, r_quo[DATA_W-1]};
  assign w_diff   = w_shift - {1'b0, r_dvs};
  assign w_qbit   = ~w_diff[DATA_W];
  assign quotient = {r_quo[DATA_W-2:0], w_qbit};
  assign done     = r_busy & (r_cnt == CntW'(DATA_W - 1));
  assign busy     = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
    end else if (kill) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= dividend;
      r_dvs  <= divisor;
    end else if (r_busy) begin
      r_rem <= w_qbit ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
      r_quo <= quotient;
      r_cnt <= r_cnt + CntW'(1);
      if (done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_mc.sv
// Registered execute stage: single-cycle ALU/MUL/branch ops plus iterative DIV.
// Define EX_SIGNED_BLT_EN to make BLT a signed compare (unsigned otherwise).
module ex_mc
  import ex_mc_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RADDR_W = 3,
  parameter int unsigned PC_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [15:0]        inst_i,
  input  logic [PC_W-1:0]    inst_addr_i,
  input  logic [DATA_W-1:0]  op1_i,
  input  logic [DATA_W-1:0]  op2_i,
  input  logic [RADDR_W-1:0] rd_addr_i,
  input  logic               reg_wen_i,
  output logic               valid_o,
  output logic [RADDR_W-1:0] rd_addr_o,
  output logic [DATA_W-1:0]  rd_data_o,
  output logic               rd_wen_o,
  output logic [5:0]         jump_offset_o,
  output logic               jump_en_o,
  output logic               busy_o
);

  ex_state_e          r_state, w_state_nxt;
  logic [3:0]         w_opc;
  logic [5:0]         w_off;
  logic               w_accept, w_div_start, w_div_done, w_div_busy;
  logic [DATA_W-1:0]  w_quotient, w_alu_res;
  logic               w_wr, w_taken, w_blt;
  logic [RADDR_W-1:0] r_div_rd;
  logic               r_div_wen;
  logic               r_valid, r_wen, r_jen;
  logic [RADDR_W-1:0] r_addr;
  logic [DATA_W-1:0]  r_data;
  logic [5:0]         r_off;
  logic               w_valid_d, w_wen_d, w_jen_d;
  logic [RADDR_W-1:0] w_addr_d;
  logic [DATA_W-1:0]  w_data_d;
  logic [5:0]         w_off_d;
  logic               w_unused;

  assign w_opc       = inst_i[OPC_MSB:OPC_LSB];
  assign w_off       = inst_i[OFF_MSB:OFF_LSB];
  assign w_unused    = ^{inst_addr_i, inst_i[OFF_LSB-1:OPC_MSB+1]};
  assign ready_o     = (r_state == StIdle) & ~flush_i;
  assign w_accept    = valid_i & ready_o;
  assign w_div_start = w_accept & (w_opc == DIV_op) & (op2_i != '0);

`ifdef EX_SIGNED_BLT_EN
  assign w_blt = $signed(op1_i) < $signed(op2_i);
`else
  assign w_blt = op1_i < op2_i;
`endif

  ex_div_iter #(
    .DATA_W(DATA_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_div_start),
    .kill    (flush_i),
    .dividend(op1_i),
    .divisor (op2_i),
    .busy    (w_div_busy),
    .done    (w_div_done),
    .quotient(w_quotient)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_div_start) w_state_nxt = StDiv;
      StDiv:   if (w_div_done) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (flush_i) w_state_nxt = StIdle;
  end

  // Divide-by-zero reaches here only with op2 == 0 and returns all-ones in one cycle.
  always_comb begin
    w_alu_res = '0;
    w_wr      = 1'b0;
    w_taken   = 1'b0;
    case (w_opc)
      ADD_op, ADDI_op: begin w_alu_res = op1_i + op2_i; w_wr = 1'b1; end
      SUB_op:          begin w_alu_res = op1_i - op2_i; w_wr = 1'b1; end
      MUL_op:          begin w_alu_res = op1_i * op2_i; w_wr = 1'b1; end
      DIV_op:          begin w_alu_res = '1;            w_wr = 1'b1; end
      AND_op:          begin w_alu_res = op1_i & op2_i; w_wr = 1'b1; end
      OR_op:           begin w_alu_res = op1_i | op2_i; w_wr = 1'b1; end
      NOT_op:          begin w_alu_res = ~op1_i;        w_wr = 1'b1; end
      MOV_op:          begin w_alu_res = op2_i;         w_wr = 1'b1; end
      BNE_op:          w_taken = (op1_i != op2_i);
      BLT_op:          w_taken = w_blt;
      default:         ;
    endcase
  end

  always_comb begin
    w_valid_d = 1'b0;
    w_wen_d   = 1'b0;
    w_jen_d   = 1'b0;
    w_addr_d  = '0;
    w_data_d  = '0;
    w_off_d   = '0;
    if (!flush_i) begin
      if (w_div_done) begin
        w_valid_d = 1'b1;
        w_data_d  = w_quotient;
        w_addr_d  = r_div_rd;
        w_wen_d   = r_div_wen;
      end else if (w_accept && !w_div_start) begin
        w_valid_d = 1'b1;
        if (w_wr) begin
          w_data_d = w_alu_res;
          w_addr_d = rd_addr_i;
          w_wen_d  = reg_wen_i;
        end
        if (w_taken) begin
          w_jen_d = 1'b1;
          w_off_d = w_off;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_div_rd  <= '0;
      r_div_wen <= 1'b0;
      r_valid   <= 1'b0;
      r_wen     <= 1'b0;
      r_jen     <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_off     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_div_start) begin
        r_div_rd  <= rd_addr_i;
        r_div_wen <= reg_wen_i;
      end
      r_valid <= w_valid_d;
      r_wen   <= w_wen_d;
      r_jen   <= w_jen_d;
      r_addr  <= w_addr_d;
      r_data  <= w_data_d;
      r_off   <= w_off_d;
    end
  end

  assign valid_o       = r_valid;
  assign rd_wen_o      = r_wen;
  assign rd_addr_o     = r_addr;
  assign rd_data_o     = r_data;
  assign jump_offset_o = r_off;
  assign jump_en_o     = r_jen;
  assign busy_o        = w_div_busy;

endmodule

// File: tb/tb_ex_mc.sv
// Self-checking bench for ex_mc: directed literal checks plus random traffic compared
// every cycle against a cycle-level behavioural model of the stage.
module tb_ex_mc;
  import ex_mc_pkg::*;

  localparam int DW = 16;
  localparam int RW = 3;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [15:0]   inst_i = '0;
  logic [PW-1:0] inst_addr_i = '0;
  logic [DW-1:0] op1_i = '0;
  logic [DW-1:0] op2_i = '0;
  logic [RW-1:0] rd_addr_i = '0;
  logic          reg_wen_i = 1'b0;
  logic          valid_o;
  logic [RW-1:0] rd_addr_o;
  logic [DW-1:0] rd_data_o;
  logic          rd_wen_o;
  logic [5:0]    jump_offset_o;
  logic          jump_en_o;
  logic          busy_o;

  always #5 clk = ~clk;

  ex_mc #(.DATA_W(DW), .RADDR_W(RW), .PC_W(PW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .inst_i       (inst_i),
    .inst_addr_i  (inst_addr_i),
    .op1_i        (op1_i),
    .op2_i        (op2_i),
    .rd_addr_i    (rd_addr_i),
    .reg_wen_i    (reg_wen_i),
    .valid_o      (valid_o),
    .rd_addr_o    (rd_addr_o),
    .rd_data_o    (rd_data_o),
    .rd_wen_o     (rd_wen_o),
    .jump_offset_o(jump_offset_o),
    .jump_en_o    (jump_en_o),
    .busy_o       (busy_o)
  );

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
    logic          wen;
    logic [5:0]    off;
    logic          jen;
  } res_t;

  int n_checks = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  // Model state: expected registered outputs and cycles of division still outstanding.
  res_t          exp_r;
  int            div_left;
  logic [DW-1:0] div_q;
  logic [RW-1:0] div_rd;
  logic          div_wen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic res_t model_single(input logic [15:0] inst, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b, input logic [RW-1:0] rd,
                                        input logic wen);
    res_t r;
    logic taken;
    logic wr;
    r = '0;
    r.valid = 1'b1;
    taken = 1'b0;
    wr = 1'b1;
    case (inst[3:0])
      ADD_op, ADDI_op: r.data = a + b;
      SUB_op:          r.data = a - b;
      MUL_op:          r.data = a * b;
      DIV_op:          r.data = '1;
      AND_op:          r.data = a & b;
      OR_op:           r.data = a | b;
      NOT_op:          r.data = ~a;
      MOV_op:          r.data = b;
      BNE_op: begin wr = 1'b0; taken = (a != b); end
      BLT_op: begin
        wr = 1'b0;
`ifdef EX_SIGNED_BLT_EN
        taken = ($signed(a) < $signed(b));
`else
        taken = (a < b);
`endif
      end
      default: wr = 1'b0;
    endcase
    if (wr) begin
      r.rd = rd;
      r.wen = wen;
    end
    r.jen = taken;
    r.off = taken ? inst[15:10] : 6'd0;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_r <= '0;
      div_left <= 0;
    end else begin
      exp_r <= '0;
      if (flush_i) begin
        div_left <= 0;
      end else if (div_left > 0) begin
        div_left <= div_left - 1;
        if (div_left == 1) exp_r <= '{valid: 1'b1, rd: div_rd, data: div_q, wen: div_wen,
                                        off: 6'd0, jen: 1'b0};
      end else if (valid_i) begin
        if (inst_i[3:0] == DIV_op && op2_i != '0) begin
          div_left <= DW;
          div_q <= op1_i / op2_i;
          div_rd <= rd_addr_i;
          div_wen <= reg_wen_i;
        end else begin
          exp_r <= model_single(inst_i, op1_i, op2_i, rd_addr_i, reg_wen_i);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("valid_o", 32'(valid_o), 32'(exp_r.valid));
      chk("rd_addr_o", 32'(rd_addr_o), 32'(exp_r.rd));
      chk("rd_data_o", 32'(rd_data_o), 32'(exp_r.data));
      chk("rd_wen_o", 32'(rd_wen_o), 32'(exp_r.wen));
      chk("jump_offset_o", 32'(jump_offset_o), 32'(exp_r.off));
      chk("jump_en_o", 32'(jump_en_o), 32'(exp_r.jen));
      chk("busy_o", 32'(busy_o), 32'(div_left > 0));
      chk("ready_o", 32'(ready_o), 32'(div_left == 0 && !flush_i));
    end
  end

  task automatic set_op(input logic [3:0] opc, input logic [5:0] off, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [RW-1:0] rd, input logic wen);
    valid_i = 1'b1;
    inst_i = {off, 6'd0, opc};
    op1_i = a;
    op2_i = b;
    rd_addr_i = rd;
    reg_wen_i = wen;
  endtask

  task automatic idle_in();
    valid_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".valid_o"}, 32'(valid_o), 32'd0);
    chk({tag, ".rd_data_o"}, 32'(rd_data_o), 32'd0);
    chk({tag, ".jump_en_o"}, 32'(jump_en_o), 32'd0);
    chk({tag, ".busy_o"}, 32'(busy_o), 32'd0);
    chk({tag, ".ready_o"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    logic blt_exp;
    logic [3:0] opc;
    #2;
    chk_quiet("reset");
    chk("reset.rd_wen_o", 32'(rd_wen_o), 32'd0);
    check_en = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b1;
    next();

    set_op(ADD_op, 6'd0, 16'h7FFF, 16'h0003, 3'd5, 1'b1);
    next();
    set_op(SUB_op, 6'd0, 16'd3, 16'd5, 3'd2, 1'b1);
    @(negedge clk);
    chk("add.valid_o", 32'(valid_o), 32'd1);
    chk("add.rd_data_o", 32'(rd_data_o), 32'h8002);
    chk("add.rd_addr_o", 32'(rd_addr_o), 32'd5);
    chk("add.rd_wen_o", 32'(rd_wen_o), 32'd1);
    next();
    idle_in();
    @(negedge clk);
    chk("sub.rd_data_o", 32'(rd_data_o), 32'hFFFE);
    next();

    set_op(DIV_op, 6'd0, 16'd100, 16'd7, 3'd3, 1'b1);
    next();
    idle_in();
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("div.ready_o", 32'(ready_o), 32'd0);
      chk("div.busy_o", 32'(busy_o), 32'd1);
      chk("div.early_valid", 32'(valid_o), 32'd0);
      next();
    end
    @(negedge clk);
    chk("div.valid_o", 32'(valid_o), 32'd1);
    chk("div.rd_data_o", 32'(rd_data_o), 32'd14);
    chk("div.rd_addr_o", 32'(rd_addr_o), 32'd3);
    next();

    set_op(DIV_op, 6'd0, 16'd9, 16'd0, 3'd1, 1'b1);
    next();
    set_op(BNE_op, 6'h2A, 16'd4, 16'd5, 3'd6, 1'b1);
    @(negedge clk);
    chk("div0.rd_data_o", 32'(rd_data_o), 32'hFFFF);
    chk("div0.busy_o", 32'(busy_o), 32'd0);
    next();
    set_op(BNE_op, 6'h2A, 16'd4, 16'd4, 3'd6, 1'b1);
    @(negedge clk);
    chk("bne_t.jump_en_o", 32'(jump_en_o), 32'd1);
    chk("bne_t.jump_offset_o", 32'(jump_offset_o), 32'h2A);
    chk("bne_t.rd_wen_o", 32'(rd_wen_o), 32'd0);
    next();
    set_op(BLT_op, 6'h15, 16'hFFFF, 16'd1, 3'd2, 1'b1);
    @(negedge clk);
    chk("bne_nt.jump_en_o", 32'(jump_en_o), 32'd0);
    chk("bne_nt.jump_offset_o", 32'(jump_offset_o), 32'd0);
    chk("bne_nt.valid_o", 32'(valid_o), 32'd1);
    next();
    idle_in();
`ifdef EX_SIGNED_BLT_EN
    blt_exp = 1'b1;
`else
    blt_exp = 1'b0;
`endif
    @(negedge clk);
    chk("blt.jump_en_o", 32'(jump_en_o), 32'(blt_exp));
    next();

    // Flush part-way through a division; an op offered alongside the flush is dropped.
    set_op(DIV_op, 6'd0, 16'd100, 16'd7, 3'd4, 1'b1);
    next();
    idle_in();
    repeat (4) next();
    flush_i = 1'b1;
    set_op(ADD_op, 6'd0, 16'd9, 16'd9, 3'd1, 1'b1);
    @(negedge clk);
    chk("flush.ready_o", 32'(ready_o), 32'd0);
    next();
    flush_i = 1'b0;
    set_op(ADD_op, 6'd0, 16'd1, 16'd1, 3'd7, 1'b1);
    @(negedge clk);
    chk("flush.next_ready", 32'(ready_o), 32'd1);
    chk("flush.busy_o", 32'(busy_o), 32'd0);
    chk("flush.valid_o", 32'(valid_o), 32'd0);
    next();
    idle_in();
    @(negedge clk);
    chk("flush.add_data", 32'(rd_data_o), 32'd2);
    repeat (20) next();

    // Asynchronous reset in the middle of a division.
    set_op(DIV_op, 6'd0, 16'd200, 16'd3, 3'd2, 1'b1);
    next();
    idle_in();
    repeat (3) next();
    #2 rst_n = 1'b0;
    #1;
    chk_quiet("midreset");
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (20) next();

    for (int c = 0; c < 4000; c++) begin
      flush_i = ($urandom_range(0, 19) == 0);
      valid_i = ($urandom_range(0, 3) != 0);
      opc = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) opc = DIV_op;
      inst_i = 16'($urandom);
      inst_i[3:0] = opc;
      inst_addr_i = 4'($urandom);
      op1_i = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       op2_i = '0;
        1:       op2_i = op1_i;
        2:       op2_i = 16'($urandom_range(1, 15));
        default: op2_i = 16'($urandom);
      endcase
      rd_addr_i = 3'($urandom);
      reg_wen_i = 1'($urandom);
      next();
    end
    idle_in();
    repeat (20) next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ex_mc.md
Name: ex_mc

Overview:
- Parametrised, registered successor to the combinational execute stage.
- Sits between the decode/operand-read stage and regfile write-back / Br_ctrl.
- ALU, MUL and branch-resolution ops take one cycle. DIV uses an iterative restoring divider.
- valid/ready handshake on input; registered result/branch outputs; flush input for branch recovery.

Parameters:
- DATA_W, 16, operand/result width (>=4)
- RADDR_W, 3, register address width
- PC_W, 4, instruction address width (carried for debug, unused in datapath)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- flush_i  in  1  kill in-flight op and pending outputs
- valid_i  in  1  instruction/operands valid
- ready_o  out  1  stage can accept this cycle
- inst_i  in  16  instruction: opcode [3:0], offset [15:10]
- inst_addr_i  in  PC_W  instruction address
- op1_i  in  DATA_W  operand 1
- op2_i  in  DATA_W  operand 2 / immediate
- rd_addr_i  in  RADDR_W  destination register
- reg_wen_i  in  1  decoder write-enable (passed through, ANDed with op class)
- valid_o  out  1  result valid, one-cycle pulse per instruction
- rd_addr_o  out  RADDR_W  write-back address
- rd_data_o  out  DATA_W  write-back data
- rd_wen_o  out  1  write-back enable (only while valid_o)
- jump_offset_o  out  6  branch offset to Br_ctrl
- jump_en_o  out  1  branch taken pulse
- busy_o  out  1  divider iterating

Behaviour:
- Reset (rst_n=0, async): every output 0 except ready_o=1. FSM=IDLE; divider regs cleared.
- Accept = valid_i & ready_o.
- ready_o = (state==IDLE) & ~flush_i.
- FSM states: IDLE, DIV.
- IDLE, accept of non-DIV op: results registered, valid_o=1 the next cycle (latency 1).
- ADD/ADDI: op1+op2. SUB: op1-op2. MUL: low DATA_W bits of product. AND, OR: bitwise. NOT: ~op1. MOV: op2. All mod 2^DATA_W.
- ALU ops: rd_wen_o = reg_wen_i.
- Branch ops: BNE taken if op1!=op2; BLT taken if op1<op2 (unsigned).
  - Taken: jump_en_o=1, jump_offset_o=inst_i[15:10].
  - Not taken: jump_en_o=0, jump_offset_o=0.
  - rd_wen_o=0, rd_data_o=0, rd_addr_o=0. valid_o=1 either way.
- Unknown opcode: valid_o=1, all other outputs 0 (acts as NOP).
- Branch/result outputs are valid only in valid_o cycles. Outside those cycles they are driven to 0; no latched values.
- IDLE, accept of DIV with op2!=0:
  - Capture operands; enter DIV; busy_o=1.
  - One quotient bit per cycle, MSB first, DATA_W cycles.
  - Last iteration cycle: return to IDLE. valid_o=1 with quotient next cycle.
  - Total latency DATA_W+1 cycles; ready_o=0 for DATA_W cycles.
- DIV with op2==0: latency 1, quotient all-ones, no DIV state entry.
- Back-to-back single-cycle ops: one accept per cycle, outputs follow 1 cycle later.
- flush_i=1: next cycle valid_o=0, jump_en_o=0, rd_wen_o=0. FSM to IDLE, divider discarded, busy_o=0. An instruction presented the same cycle is not accepted (ready_o=0).
- Reset mid-division: immediate return to IDLE, no result emitted.

Optional Feature:
- Macro: EX_SIGNED_BLT_EN.
- Defined: BLT compares op1/op2 as two's-complement signed DATA_W values.
- Undefined: unsigned compare. All other ops unaffected in both cases.

Decomposition:
- Opcode constants stay in the shared defines.v (ADD_op ... BLT_op). Add DIV state encoding and field positions (OPC_LSB/MSB, OFF_LSB/MSB) there.
- One sub-module: ex_div_iter (restoring divider).
  - Ports: clk, rst_n, start, kill, dividend, divisor, busy, done, quotient.
  - Parametrised by DATA_W.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately, ready_o=1.
- ADD op1=0x7FFF op2=0x0003 rd=5 reg_wen=1 -> next cycle valid_o=1, rd_data_o=0x8002, rd_addr_o=5, rd_wen_o=1. SUB 3-5 -> 0xFFFE.
- DIV 100/7, DATA_W=16 -> ready_o=0 and busy_o=1 for 16 cycles; cycle 17 valid_o=1, rd_data_o=14. DIV 9/0 -> next cycle rd_data_o=0xFFFF.
- BNE 4!=5, offset 0x2A -> jump_en_o=1, jump_offset_o=0x2A, rd_wen_o=0. BNE 4==4 -> jump_en_o=0, offset 0.
- BLT op1=0xFFFF op2=1 -> not taken without EX_SIGNED_BLT_EN; taken with it.
- Flush: start DIV 100/7, flush_i at iteration 5 -> no valid_o ever for it; ready_o=1 next cycle; following ADD 1+1 returns 2 at latency 1.
